// File: rtl/ppu_pipeline_ctrl.sv
// ppu_pipeline_ctrl
// Carries the decoded 17-bit control bundle through the ID/EX, EX/MEM and
// MEM/WB boundaries and unpacks it per stage. It also flags load-use hazards
// against the instruction in EX and turns stalled or flushed slots into
// all-zero bubbles.
module ppu_pipeline_ctrl #(
   parameter int CW = 17,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [CW-1:0] control_signals,
   input  logic [RW-1:0] id_dest,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic          id_uses_rt,
   input  logic          ext_stall,
   input  logic          flush,
   output logic          load_use_stall,
   output logic [2:0]    ex_src_op,
   output logic [2:0]    ex_alu_op,
   output logic          ex_b_instr,
   output logic          ex_ta_instr,
   output logic [1:0]    mem_size,
   output logic          mem_rw,
   output logic          mem_se,
   output logic          mem_enable,
   output logic          wb_rf_enable,
   output logic          wb_load,
   output logic          wb_hi_en,
   output logic          wb_lo_en,
   output logic [RW-1:0] wb_dest,
   output logic          ex_valid,
   output logic          mem_valid,
   output logic          wb_valid
);

   // ID/EX stage register
   logic [CW-1:0] r_ex_bundle;
   logic [RW-1:0] r_ex_dest;
   logic          r_ex_valid;

   // EX/MEM stage register
   logic [1:0]    r_mem_size;
   logic          r_mem_rw;
   logic          r_mem_se;
   logic          r_mem_enable;
   logic          r_mem_load;
   logic          r_mem_rf_en;
   logic          r_mem_hi_en;
   logic          r_mem_lo_en;
   logic [RW-1:0] r_mem_dest;
   logic          r_mem_valid;

   // MEM/WB stage register
   logic          r_wb_load;
   logic          r_wb_rf_en;
   logic          r_wb_hi_en;
   logic          r_wb_lo_en;
   logic [RW-1:0] r_wb_dest;
   logic          r_wb_valid;

   logic          w_ex_load;
   logic          w_rs_hit;
   logic          w_rt_hit;
   logic          w_stall;
   logic          w_bubble;

   assign w_ex_load = r_ex_bundle[10];

   // Load-use hazard: a valid load in EX whose non-zero dest feeds the ID instruction.
   always_comb begin
      w_rs_hit = 1'b0;
      w_rt_hit = 1'b0;
      w_stall  = 1'b0;
      if (r_ex_valid && w_ex_load && (r_ex_dest != {RW{1'b0}})) begin
         w_rs_hit = (r_ex_dest == id_rs);
         w_rt_hit = id_uses_rt && (r_ex_dest == id_rt);
         w_stall  = w_rs_hit || w_rt_hit;
      end else begin
         w_rs_hit = 1'b0;
         w_rt_hit = 1'b0;
         w_stall  = 1'b0;
      end
   end

   assign load_use_stall = w_stall;
   // A flush and a stall both yield a single bubble; ID is not buffered here.
   assign w_bubble       = flush || w_stall || ext_stall;

   // ID/EX: capture the decoded bundle or insert a bubble on flush/stall.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ex_bundle <= {CW{1'b0}};
         r_ex_dest   <= {RW{1'b0}};
         r_ex_valid  <= 1'b0;
      end else if (w_bubble) begin
         r_ex_bundle <= {CW{1'b0}};
         r_ex_dest   <= {RW{1'b0}};
         r_ex_valid  <= 1'b0;
      end else begin
         r_ex_bundle <= control_signals;
         r_ex_dest   <= id_dest;
         r_ex_valid  <= 1'b1;
      end
   end

   // EX/MEM: forward memory and write-back fields; never stalled or flushed.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem_size   <= 2'b00;
         r_mem_rw     <= 1'b0;
         r_mem_se     <= 1'b0;
         r_mem_enable <= 1'b0;
         r_mem_load   <= 1'b0;
         r_mem_rf_en  <= 1'b0;
         r_mem_hi_en  <= 1'b0;
         r_mem_lo_en  <= 1'b0;
         r_mem_dest   <= {RW{1'b0}};
         r_mem_valid  <= 1'b0;
      end else begin
         r_mem_size   <= r_ex_bundle[6:5];
         r_mem_rw     <= r_ex_bundle[4];
         r_mem_se     <= r_ex_bundle[3];
         r_mem_enable <= r_ex_bundle[0];
         r_mem_load   <= r_ex_bundle[10];
         r_mem_rf_en  <= r_ex_bundle[9];
         r_mem_hi_en  <= r_ex_bundle[2];
         r_mem_lo_en  <= r_ex_bundle[1];
         r_mem_dest   <= r_ex_dest;
         r_mem_valid  <= r_ex_valid;
      end
   end

   // MEM/WB: forward write-back fields; RF write to R0 is suppressed here so the output stays registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wb_load  <= 1'b0;
         r_wb_rf_en <= 1'b0;
         r_wb_hi_en <= 1'b0;
         r_wb_lo_en <= 1'b0;
         r_wb_dest  <= {RW{1'b0}};
         r_wb_valid <= 1'b0;
      end else begin
         r_wb_load  <= r_mem_load;
         r_wb_rf_en <= r_mem_rf_en && (r_mem_dest != {RW{1'b0}});
         r_wb_hi_en <= r_mem_hi_en;
         r_wb_lo_en <= r_mem_lo_en;
         r_wb_dest  <= r_mem_dest;
         r_wb_valid <= r_mem_valid;
      end
   end

   assign ex_src_op    = r_ex_bundle[16:14];
   assign ex_alu_op    = r_ex_bundle[13:11];
   assign ex_b_instr   = r_ex_bundle[8];
   assign ex_ta_instr  = r_ex_bundle[7];
   assign ex_valid     = r_ex_valid;

   assign mem_size     = r_mem_size;
   assign mem_rw       = r_mem_rw;
   assign mem_se       = r_mem_se;
   assign mem_enable   = r_mem_enable;
   assign mem_valid    = r_mem_valid;

   assign wb_rf_enable = r_wb_rf_en;
   assign wb_load      = r_wb_load;
   assign wb_hi_en     = r_wb_hi_en;
   assign wb_lo_en     = r_wb_lo_en;
   assign wb_dest      = r_wb_dest;
   assign wb_valid     = r_wb_valid;

endmodule
